// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_pkg
//  Purpose  : Shared definitions for the bit-serial subtractor slice:
//             FSM state encoding, default operand width and the signed
//             overflow helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

    // State encoding. The fourth code (2'd3) is never entered and recovers
    // to IDLE through the default branch of the next-state logic.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

    // Two's-complement overflow of a - b: operands of opposite sign and a
    // result whose sign differs from the minuend.
    function automatic logic signed_sub_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb
    );
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage : serial_pkg
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : start/busy/done handshake and operand/result bus of the
//             bit-serial subtractor.
//  Signals  : start            - request, sampled only while idle
//             a, b   [WIDTH]   - minuend / subtrahend
//             busy             - operation in flight
//             done             - single-cycle result-valid pulse
//             diff   [WIDTH]   - a - b modulo 2^WIDTH
//             borrow           - final borrow-out (unsigned a < b)
//             overflow         - signed overflow of a - b
//  Modports : master - requester side, slave - subtractor side
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = serial_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, overflow
    );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : full_subtractor
//  Purpose  : One-bit full subtractor cell, computes a - b - bin.
//  Ports    : a_i    - minuend bit
//             b_i    - subtrahend bit
//             bin_i  - borrow in
//             d_o    - difference bit
//             bout_o - borrow out
//  Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    // Borrow when b exceeds a outright, or when they tie and a borrow ripples in.
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first,
//             one bit per clock through a single full-subtractor cell.
//             An accepted start is followed by WIDTH SHIFT cycles and one
//             DONE cycle; results are registered on entry to DONE and held
//             until the next operation completes.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - serial_subtractor_if.slave (start/a/b in,
//                     busy/done/diff/borrow/overflow out)
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,          // legal range 2..32
    parameter int CNT_W = $clog2(WIDTH + 1)   // derived, do not override
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e             state_q,    state_d;
    logic [WIDTH-1:0]   a_sr_q,     a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,     b_sr_d;
    logic [WIDTH-1:0]   res_sr_q,   res_sr_d;
    logic               bflop_q,    bflop_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               a_msb_q,    a_msb_d;
    logic               b_msb_q,    b_msb_d;
    logic [WIDTH-1:0]   diff_q,     diff_d;
    logic               borrow_q,   borrow_d;
    logic               ovf_q,      ovf_d;

    // Serial cell outputs
    logic               cell_d;
    logic               cell_bout;

    // Shift result as it will look after the current bit enters at the MSB.
    logic [WIDTH-1:0]   res_next;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // ------------------------------------------------------------------------
    // Single full-subtractor cell working on the operand LSBs
    // ------------------------------------------------------------------------
    full_subtractor u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (bflop_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    assign res_next = {cell_d, res_sr_q[WIDTH-1:1]};

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        bflop_d  = bflop_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    bflop_d = 1'b0;
                    cnt_d   = '0;
                    // Operand signs are kept aside because the operand
                    // registers are shifted away during SHIFT.
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_next;
                bflop_d  = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                // The counter holds the index of the bit being processed, so
                // index WIDTH-1 is the last of WIDTH shifts. The result
                // outputs are captured on this same edge so that they are
                // already valid while done is high.
                if (cnt_q == LAST_BIT) begin
                    diff_d   = res_next;
                    borrow_d = cell_bout;
                    ovf_d    = signed_sub_ovf(a_msb_q, b_msb_q, cell_d);
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            bflop_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            bflop_q  <= bflop_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: handshake decoded straight from the state register
    // ------------------------------------------------------------------------
    assign bus.busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = ovf_q;

endmodule : serial_subtractor
`default_nettype wire
